// File: rtl/usb_autodetect_ctrl.sv
`timescale 1ns/1ps
// usb_autodetect_ctrl: passive LS/FS/HS bus-speed detector.
// Sequences the PHY transceiver config and classifies debounced UTMI linestate.
// Handshake: I_restart is a single-cycle request that is always accepted, from any
// state. O_busy is high from the cycle after the request until the result is ready.
// O_done/O_speed/O_xcvrsel/O_termsel then hold the result until the next I_restart.
module usb_autodetect_ctrl #(
   parameter int pCOUNTER_WIDTH = 24,
   parameter int pCHIRP_PAIRS   = 3,
   parameter int pSTABLE_CYCLES = 16
) (
   input  logic                      fe_clk,
   input  logic                      reset_n,
   input  logic                      I_restart,
   input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
   input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
   input  logic [1:0]                I_xcvrsel_default,
   input  logic                      I_termsel_default,
   input  logic [1:0]                I_linestate,
   output logic [1:0]                O_xcvrsel,
   output logic                      O_termsel,
   output logic [1:0]                O_speed,
   output logic                      O_busy,
   output logic                      O_done,
   output logic [2:0]                O_state
);

   localparam int SW = $clog2(pSTABLE_CYCLES + 1);
   localparam int PW = $clog2(pCHIRP_PAIRS + 1);

   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_J   = 2'b01;
   localparam logic [1:0] LS_K   = 2'b10;

   localparam logic [1:0] SPD_NONE = 2'd0;
   localparam logic [1:0] SPD_LS   = 2'd1;
   localparam logic [1:0] SPD_FS   = 2'd2;
   localparam logic [1:0] SPD_HS   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_CLASSIFY = 3'd2,
      ST_WAIT_SE0 = 3'd3,
      ST_CHIRP    = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   state_t                    state;
   logic [1:0]                ls_prev;
   logic [SW-1:0]             stable_cnt;
   logic [pCOUNTER_WIDTH-1:0] wait_cnt;
   logic [PW-1:0]             pair_cnt;
   logic                      seen_k;

   logic                      ls_stable;
   logic                      stable_k;
   logic                      stable_j;
   logic                      stable_se0;
   logic [pCOUNTER_WIDTH-1:0] lim1;
   logic [pCOUNTER_WIDTH-1:0] lim2;
   logic                      exp1;
   logic                      exp2;
   logic                      hs_hit;

   // PHY config for a final speed code: {xcvrsel, termsel}
   function automatic logic [2:0] speed_cfg(input logic [1:0] spd);
      case (spd)
         SPD_HS:  speed_cfg = 3'b00_0;
         SPD_LS:  speed_cfg = 3'b10_1;
         default: speed_cfg = 3'b01_1;
      endcase
   endfunction

   // Debounce qualifiers; the stable value is the one held in ls_prev
   always_comb begin
      ls_stable  = (stable_cnt == SW'(pSTABLE_CYCLES));
      stable_k   = ls_stable && (ls_prev == LS_K);
      stable_j   = ls_stable && (ls_prev == LS_J);
      stable_se0 = ls_stable && (ls_prev == LS_SE0);
      // A wait of 0 behaves as 1: expiry on the first cycle after entry
      lim1       = (I_wait1 == '0) ? '0 : I_wait1 - 1'b1;
      lim2       = (I_wait2 == '0) ? '0 : I_wait2 - 1'b1;
      exp1       = (wait_cnt == lim1);
      exp2       = (wait_cnt == lim2);
      hs_hit     = stable_j && seen_k && (pair_cnt == PW'(pCHIRP_PAIRS - 1));
   end

   // Linestate debounce: run length of the current value, saturating
   always_ff @(posedge fe_clk or negedge reset_n) begin
      if (!reset_n) begin
         ls_prev    <= 2'b00;
         stable_cnt <= '0;
      end else begin
         ls_prev <= I_linestate;
         if (I_restart || (I_linestate != ls_prev))
            stable_cnt <= '0;
         else if (!ls_stable)
            stable_cnt <= stable_cnt + 1'b1;
      end
   end

   // Detection FSM with registered outputs and wait/pair counters
   always_ff @(posedge fe_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         O_speed   <= SPD_NONE;
         O_busy    <= 1'b0;
         O_done    <= 1'b0;
         O_xcvrsel <= 2'b01;
         O_termsel <= 1'b1;
         wait_cnt  <= '0;
         pair_cnt  <= '0;
         seen_k    <= 1'b0;
      end else if (I_restart) begin
         state     <= ST_SETTLE;
         O_speed   <= SPD_NONE;
         O_busy    <= 1'b1;
         O_done    <= 1'b0;
         O_xcvrsel <= 2'b01;
         O_termsel <= 1'b1;
         wait_cnt  <= '0;
         pair_cnt  <= '0;
         seen_k    <= 1'b0;
      end else begin
         if (wait_cnt != '1)
            wait_cnt <= wait_cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               O_xcvrsel <= I_xcvrsel_default;
               O_termsel <= I_termsel_default;
            end
            ST_SETTLE: begin
               if (exp1) begin
                  state    <= ST_CLASSIFY;
                  wait_cnt <= '0;
               end
            end
            ST_CLASSIFY: begin
               if (stable_k) begin
                  state                  <= ST_DONE;
                  O_speed                <= SPD_LS;
                  O_done                 <= 1'b1;
                  O_busy                 <= 1'b0;
                  {O_xcvrsel, O_termsel} <= speed_cfg(SPD_LS);
               end else if (stable_j) begin
                  state    <= ST_WAIT_SE0;
                  O_speed  <= SPD_FS;
                  wait_cnt <= '0;
               end else if (stable_se0) begin
                  state    <= ST_CHIRP;
                  wait_cnt <= '0;
                  pair_cnt <= '0;
                  seen_k   <= 1'b0;
               end else if (exp2) begin
                  state                  <= ST_DONE;
                  O_speed                <= SPD_NONE;
                  O_done                 <= 1'b1;
                  O_busy                 <= 1'b0;
                  {O_xcvrsel, O_termsel} <= speed_cfg(SPD_NONE);
               end
            end
            ST_WAIT_SE0: begin
               if (stable_se0) begin
                  state    <= ST_CHIRP;
                  wait_cnt <= '0;
                  pair_cnt <= '0;
                  seen_k   <= 1'b0;
               end else if (exp2) begin
                  state                  <= ST_DONE;
                  O_speed                <= SPD_FS;
                  O_done                 <= 1'b1;
                  O_busy                 <= 1'b0;
                  {O_xcvrsel, O_termsel} <= speed_cfg(SPD_FS);
               end
            end
            ST_CHIRP: begin
               // A pair is a stable K followed later by a stable J; SE0 in between is tolerated
               if (stable_k)
                  seen_k <= 1'b1;
               if (stable_j && seen_k) begin
                  seen_k   <= 1'b0;
                  pair_cnt <= pair_cnt + 1'b1;
               end
               if (hs_hit) begin
                  state                  <= ST_DONE;
                  O_speed                <= SPD_HS;
                  O_done                 <= 1'b1;
                  O_busy                 <= 1'b0;
                  {O_xcvrsel, O_termsel} <= speed_cfg(SPD_HS);
               end else if (exp2) begin
                  state                  <= ST_DONE;
                  O_speed                <= SPD_FS;
                  O_done                 <= 1'b1;
                  O_busy                 <= 1'b0;
                  {O_xcvrsel, O_termsel} <= speed_cfg(SPD_FS);
               end
            end
            ST_DONE: begin
               O_done <= 1'b1;
               O_busy <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign O_state = state;

endmodule

// File: tb/tb_usb_autodetect_ctrl.sv
`timescale 1ns/1ps
// Bench for usb_autodetect_ctrl: directed scenarios plus randomised linestate
// sequences, checked against a reference computed from the detection rules.
module tb_usb_autodetect_ctrl;

   localparam int CW = 24;
   localparam int P  = 3;
   localparam int S  = 16;
   localparam int EW = 37;  // {done edge[31:0], speed[1:0], xcvrsel[1:0], termsel}

   logic          fe_clk;
   logic          reset_n;
   logic          I_restart;
   logic [CW-1:0] I_wait1;
   logic [CW-1:0] I_wait2;
   logic [1:0]    I_xcvrsel_default;
   logic          I_termsel_default;
   logic [1:0]    I_linestate;
   logic [1:0]    O_xcvrsel;
   logic          O_termsel;
   logic [1:0]    O_speed;
   logic          O_busy;
   logic          O_done;
   logic [2:0]    O_state;

   usb_autodetect_ctrl #(
      .pCOUNTER_WIDTH(CW), .pCHIRP_PAIRS(P), .pSTABLE_CYCLES(S)
   ) dut (
      .fe_clk(fe_clk), .reset_n(reset_n), .I_restart(I_restart),
      .I_wait1(I_wait1), .I_wait2(I_wait2),
      .I_xcvrsel_default(I_xcvrsel_default), .I_termsel_default(I_termsel_default),
      .I_linestate(I_linestate), .O_xcvrsel(O_xcvrsel), .O_termsel(O_termsel),
      .O_speed(O_speed), .O_busy(O_busy), .O_done(O_done), .O_state(O_state)
   );

   // ---------------- clock / reset ----------------
   initial fe_clk = 1'b0;
   always #5 fe_clk = ~fe_clk;

   int unsigned cyc = 0;       // number of rising edges so far
   initial forever begin
      @(posedge fe_clk);
      cyc++;
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic [1:0]    ls_arr[$];   // linestate per edge, index 0 = restart edge
   int            n_cmp = 0;
   int            n_err = 0;
   int            done_count = 0;

   task automatic check(input string name, input longint unsigned act, input longint unsigned req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [2:0] cfg_of(input logic [1:0] spd);
      case (spd)
         2'd3:    cfg_of = 3'b000;
         2'd1:    cfg_of = 3'b101;
         default: cfg_of = 3'b011;
      endcase
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [1:0] ls_at(input int i);
      if (i >= ls_arr.size()) return ls_arr[ls_arr.size()-1];
      return ls_arr[i];
   endfunction

   // Stable at edge k: the previous S+1 samples since restart are all the same value
   function automatic bit stable_at(input int k, output logic [1:0] v);
      v = ls_at(k-1);
      if (k < S + 1) return 1'b0;
      for (int j = k - S - 1; j < k; j++)
         if (ls_at(j) != v) return 1'b0;
      return 1'b1;
   endfunction

   // Returns the edge (relative to the restart edge) on which DONE is entered, and the speed
   function automatic void model(input int w1, input int w2, output int d, output logic [1:0] spd);
      int n1, n2, entry, k, ph, pairs;
      bit seenk, st;
      logic [1:0] v;
      n1 = (w1 == 0) ? 1 : w1;
      n2 = (w2 == 0) ? 1 : w2;
      entry = n1; ph = 0; pairs = 0; seenk = 0; k = n1;
      d = 0; spd = 2'd0;
      while (1) begin
         k++;
         st = stable_at(k, v);
         if (ph == 0) begin
            if (st && v == 2'b10) begin d = k; spd = 2'd1; return; end
            if (st && v == 2'b01) begin ph = 1; entry = k; continue; end
            if (st && v == 2'b00) begin ph = 2; entry = k; continue; end
            if (k == entry + n2) begin d = k; spd = 2'd0; return; end
         end else if (ph == 1) begin
            if (st && v == 2'b00) begin ph = 2; entry = k; continue; end
            if (k == entry + n2) begin d = k; spd = 2'd2; return; end
         end else begin
            if (st && v == 2'b10) seenk = 1;
            else if (st && v == 2'b01 && seenk) begin
               seenk = 0;
               pairs++;
               if (pairs == P) begin d = k; spd = 2'd3; return; end
            end
            if (k == entry + n2) begin d = k; spd = 2'd2; return; end
         end
      end
   endfunction

   // ---------------- monitor ----------------
   initial begin
      logic done_q;
      logic [EW-1:0] e;
      done_q = 1'b0;
      forever begin
         @(negedge fe_clk);
         if (!reset_n) done_q = 1'b0;
         else begin
            if (O_done && !done_q) begin
               done_count++;
               if (exp_q.size() == 0) check("unexpected_done", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("done_edge", cyc, e[36:5]);
                  check("speed", O_speed, e[4:3]);
                  check("xcvrsel", O_xcvrsel, e[2:1]);
                  check("termsel", O_termsel, e[0]);
                  check("busy_at_done", O_busy, 0);
               end
            end
            done_q = O_done;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic seg(input logic [1:0] v, input int len);
      repeat (len) ls_arr.push_back(v);
   endtask

   task automatic run_test(input int w1, input int w2);
      int d, r, i, c0;
      logic [1:0] spd;
      model(w1, w2, d, spd);
      @(negedge fe_clk);
      c0 = done_count;
      I_wait1 = CW'(w1);
      I_wait2 = CW'(w2);
      I_restart = 1'b1;
      I_linestate = ls_at(0);
      r = int'(cyc) + 1;
      exp_q.push_back({32'(r + d), spd, cfg_of(spd)});
      i = 1;
      while (done_count == c0 && i <= d + 40) begin
         @(negedge fe_clk);
         I_restart = 1'b0;
         if (i == 1) begin
            check("busy_after_restart", O_busy, 1);
            check("done_after_restart", O_done, 0);
            check("speed_after_restart", O_speed, 0);
         end
         I_linestate = ls_at(i);
         i++;
      end
      if (done_count == c0) begin
         check("done_timeout", 0, 1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
   endtask

   // Starts a run that is cut short after 'edges' edges; no result expected
   task automatic start_partial(input int w1, input int w2, input int edges);
      @(negedge fe_clk);
      I_wait1 = CW'(w1);
      I_wait2 = CW'(w2);
      I_restart = 1'b1;
      I_linestate = ls_at(0);
      for (int i = 1; i <= edges; i++) begin
         @(negedge fe_clk);
         I_restart = 1'b0;
         I_linestate = ls_at(i);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w1, w2, mode, np, c0;
      reset_n = 1'b0;
      I_restart = 1'b0;
      I_wait1 = '0;
      I_wait2 = '0;
      I_xcvrsel_default = 2'b10;
      I_termsel_default = 1'b0;
      I_linestate = 2'b01;

      // T1: reset values, then IDLE drives the defaults
      repeat (3) @(negedge fe_clk);
      check("rst_xcvrsel", O_xcvrsel, 2'b01);
      check("rst_termsel", O_termsel, 1);
      check("rst_speed", O_speed, 0);
      check("rst_busy", O_busy, 0);
      check("rst_done", O_done, 0);
      reset_n = 1'b1;
      @(negedge fe_clk);
      check("idle_xcvrsel", O_xcvrsel, 2'b10);
      check("idle_termsel", O_termsel, 0);
      check("idle_speed", O_speed, 0);
      check("idle_busy", O_busy, 0);
      check("idle_done", O_done, 0);

      // T2: J idle -> FS after full WAIT_SE0 window
      ls_arr.delete(); seg(2'b01, 50);
      run_test(10, 100);
      // T3: K idle -> LS
      ls_arr.delete(); seg(2'b10, 50);
      run_test(10, 100);
      // T4: J, bus reset, three chirp pairs -> HS
      ls_arr.delete(); seg(2'b01, 40); seg(2'b00, 200);
      repeat (3) begin seg(2'b10, 20); seg(2'b01, 20); end
      run_test(10, 1000);
      // T5: two real pairs plus short pairs below the debounce -> FS at expiry
      ls_arr.delete(); seg(2'b01, 40); seg(2'b00, 200);
      repeat (2) begin seg(2'b10, 20); seg(2'b01, 20); end
      repeat (4) begin seg(2'b10, 8); seg(2'b01, 8); end
      run_test(10, 1000);
      // SE1 only, never qualifies -> speed none; zero waits treated as 1
      ls_arr.delete(); seg(2'b11, 10);
      run_test(0, 30);
      ls_arr.delete(); seg(2'b10, 10);
      run_test(0, 0);

      // T6a: restart in the middle of CHIRP
      ls_arr.delete(); seg(2'b01, 40); seg(2'b00, 200);
      repeat (3) begin seg(2'b10, 20); seg(2'b01, 20); end
      start_partial(10, 1000, 250);
      check("busy_mid_chirp", O_busy, 1);
      check("speed_mid_chirp", O_speed, 2);
      run_test(10, 1000);

      // T6b: reset mid-SETTLE, no completion reported
      ls_arr.delete(); seg(2'b10, 30);
      c0 = done_count;
      start_partial(20, 100, 5);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_busy", O_busy, 0);
      check("midrst_done", O_done, 0);
      check("midrst_speed", O_speed, 0);
      check("midrst_xcvrsel", O_xcvrsel, 2'b01);
      check("midrst_termsel", O_termsel, 1);
      repeat (3) @(negedge fe_clk);
      reset_n = 1'b1;
      repeat (40) @(negedge fe_clk);
      check("midrst_no_done", done_count, c0);
      check("midrst_idle_xcvrsel", O_xcvrsel, 2'b10);

      // Randomised runs
      for (int t = 0; t < 30; t++) begin
         ls_arr.delete();
         mode = $urandom_range(0, 2);
         w1 = $urandom_range(0, 20);
         if (mode == 0) begin
            repeat ($urandom_range(3, 12)) seg(2'($urandom_range(0, 3)), $urandom_range(1, 40));
            w2 = $urandom_range(0, 250);
         end else begin
            if (mode == 1) seg(2'b01, $urandom_range(5, 50));
            seg(2'b00, $urandom_range(5, 80));
            np = $urandom_range(1, 4);
            repeat (np) begin
               seg(2'b10, $urandom_range(6, 30));
               seg(2'b01, $urandom_range(6, 30));
               if ($urandom_range(0, 3) == 0) seg(2'b00, $urandom_range(10, 30));
            end
            w2 = $urandom_range(50, 600);
         end
         run_test(w1, w2);
      end

      repeat (5) @(negedge fe_clk);
      if (exp_q.size() != 0) check("leftover_expected", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
